// File: rtl/cardinal_nic_pkg.sv
// Shared constants for the cardinal NIC: CPU register map and packet width.
package cardinal_nic_pkg;

    localparam int unsigned PktW = 64;

    localparam logic [1:0] ADDR_IN_BUF   = 2'b00;
    localparam logic [1:0] ADDR_IN_STAT  = 2'b01;
    localparam logic [1:0] ADDR_OUT_BUF  = 2'b10;
    localparam logic [1:0] ADDR_OUT_STAT = 2'b11;

endpackage

// File: rtl/nic_chan_buf.sv
// Single-entry packet buffer: data register plus full flag, with load and clear strobes.
module nic_chan_buf
    import cardinal_nic_pkg::*;
(
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            load_i,
    input  logic            clr_i,
    input  logic [0:PktW-1] data_i,
    output logic [0:PktW-1] data_o,
    output logic            full_o
);

    logic [0:PktW-1] data_d, data_q;
    logic            full_d, full_q;

    // Clear wins over load; the top never asserts both while full anyway.
    always_comb begin
        data_d = data_q;
        full_d = full_q;
        if (clr_i) begin
            full_d = 1'b0;
        end else if (load_i) begin
            data_d = data_i;
            full_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            data_q <= '0;
            full_q <= 1'b0;
        end else begin
            data_q <= data_d;
            full_q <= full_d;
        end
    end

    assign data_o = data_q;
    assign full_o = full_q;

endmodule

// File: rtl/cardinal_nic.sv
// Cardinal NIC: one-entry inbound/outbound packet buffers with a CPU register port.
// Define CARDINAL_NIC_RD_CLR_EN to clear in_full on a CPU read of the input buffer.
module cardinal_nic
    import cardinal_nic_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [0:1]  addr_nic,
    input  logic [0:63] d_in,
    output logic [0:63] d_out,
    input  logic        nicEn,
    input  logic        nicWrEn,
    input  logic        net_si,
    output logic        net_ri,
    input  logic [0:63] net_di,
    output logic        net_so,
    input  logic        net_ro,
    output logic [0:63] net_do,
    input  logic        net_polarity
);

    logic [0:PktW-1] in_data, out_data;
    logic            in_full, out_full;
    logic            in_load, in_clr, out_load, out_clr;
    logic            cpu_rd, cpu_wr;
    logic [0:63]     d_out_d, d_out_q;

    assign cpu_rd = nicEn & ~nicWrEn;
    assign cpu_wr = nicEn & nicWrEn;

    assign net_ri  = ~in_full;
    assign in_load = net_si & ~in_full;

`ifdef CARDINAL_NIC_RD_CLR_EN
    assign in_clr = cpu_rd & (addr_nic == ADDR_IN_BUF);
`else
    assign in_clr = cpu_wr & (addr_nic == ADDR_IN_STAT);
`endif

    // Packet index 0 carries the phase the router must be in to accept it.
    assign net_so   = out_full & net_ro & (net_polarity == out_data[0]);
    assign net_do   = out_data;
    assign out_clr  = net_so;
    assign out_load = cpu_wr & (addr_nic == ADDR_OUT_BUF) & ~out_full;

    nic_chan_buf u_in_buf (
        .clk_i  (clk),
        .rst_i  (rst),
        .load_i (in_load),
        .clr_i  (in_clr),
        .data_i (net_di),
        .data_o (in_data),
        .full_o (in_full)
    );

    nic_chan_buf u_out_buf (
        .clk_i  (clk),
        .rst_i  (rst),
        .load_i (out_load),
        .clr_i  (out_clr),
        .data_i (d_in),
        .data_o (out_data),
        .full_o (out_full)
    );

    always_comb begin
        d_out_d = d_out_q;
        if (cpu_rd) begin
            unique case (addr_nic)
                ADDR_IN_BUF:   d_out_d = in_data;
                ADDR_IN_STAT:  d_out_d = {63'b0, in_full};
                ADDR_OUT_BUF:  d_out_d = out_data;
                ADDR_OUT_STAT: d_out_d = {63'b0, out_full};
                default:       d_out_d = d_out_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_out_q <= '0;
        end else begin
            d_out_q <= d_out_d;
        end
    end

    assign d_out = d_out_q;

endmodule

// File: tb/tb_cardinal_nic.sv
// Directed self-checking bench for cardinal_nic; build with or without CARDINAL_NIC_RD_CLR_EN.
module tb_cardinal_nic;

    logic        clk = 1'b0;
    logic        rst;
    logic [0:1]  addr_nic;
    logic [0:63] d_in;
    logic [0:63] d_out;
    logic        nicEn;
    logic        nicWrEn;
    logic        net_si;
    logic        net_ri;
    logic [0:63] net_di;
    logic        net_so;
    logic        net_ro;
    logic [0:63] net_do;
    logic        net_polarity;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    cardinal_nic dut (
        .clk          (clk),
        .rst          (rst),
        .addr_nic     (addr_nic),
        .d_in         (d_in),
        .d_out        (d_out),
        .nicEn        (nicEn),
        .nicWrEn      (nicWrEn),
        .net_si       (net_si),
        .net_ri       (net_ri),
        .net_di       (net_di),
        .net_so       (net_so),
        .net_ro       (net_ro),
        .net_do       (net_do),
        .net_polarity (net_polarity)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cpu_rd(input logic [1:0] a);
        nicEn = 1'b1; nicWrEn = 1'b0; addr_nic = a;
        tick();
        nicEn = 1'b0;
    endtask

    task automatic cpu_wr(input logic [1:0] a, input logic [63:0] d);
        nicEn = 1'b1; nicWrEn = 1'b1; addr_nic = a; d_in = d;
        tick();
        nicEn = 1'b0; nicWrEn = 1'b0;
    endtask

    initial begin
        rst = 1'b1; addr_nic = 2'b00; d_in = '0; nicEn = 1'b0; nicWrEn = 1'b0;
        net_si = 1'b0; net_di = '0; net_ro = 1'b0; net_polarity = 1'b0;
        tick(); tick();
        check("rst_ri", 64'(net_ri), 64'd1);
        check("rst_so", 64'(net_so), 64'd0);
        check("rst_dout", d_out, 64'd0);
        check("rst_do", net_do, 64'd0);
        rst = 1'b0;
        tick();

        // Inbound capture
        net_si = 1'b1; net_di = 64'hA5A5_0000_0000_0001;
        tick();
        net_si = 1'b0;
        check("in_ri_low", 64'(net_ri), 64'd0);
        cpu_rd(2'b01);
        check("in_stat", d_out, 64'd1);

        // Inbound drop while full
        net_si = 1'b1; net_di = 64'hDEAD_BEEF_DEAD_BEEF;
        tick();
        net_si = 1'b0;
        cpu_rd(2'b00);
        check("in_buf", d_out, 64'hA5A5_0000_0000_0001);
        tick();
        check("dout_hold", d_out, 64'hA5A5_0000_0000_0001);

        // Clear mode
`ifdef CARDINAL_NIC_RD_CLR_EN
        cpu_rd(2'b01);
        check("rdclr_stat", d_out, 64'd0);
`else
        cpu_rd(2'b01);
        check("nordclr_stat", d_out, 64'd1);
        cpu_wr(2'b01, 64'h1234);
        cpu_rd(2'b01);
        check("wrclr_stat", d_out, 64'd0);
`endif
        check("ri_after_clr", 64'(net_ri), 64'd1);

        // Outbound with polarity gating
        net_ro = 1'b1; net_polarity = 1'b0;
        cpu_wr(2'b10, 64'h8000_0000_0000_00FF);
        check("out_do", net_do, 64'h8000_0000_0000_00FF);
        check("out_so_wrongpol", 64'(net_so), 64'd0);
        cpu_rd(2'b11);
        check("out_stat_full", d_out, 64'd1);
        cpu_wr(2'b10, 64'h0000_0000_0000_1234);
        check("out_drop", net_do, 64'h8000_0000_0000_00FF);
        net_polarity = 1'b1;
        #1;
        check("out_so_hi", 64'(net_so), 64'd1);
        tick();
        check("out_so_done", 64'(net_so), 64'd0);
        cpu_rd(2'b11);
        check("out_stat_empty", d_out, 64'd0);

        // Collision: write to 10 in the transfer cycle is dropped
        net_ro = 1'b0;
        cpu_wr(2'b10, 64'h8000_0000_0000_0002);
        check("col_so_wait", 64'(net_so), 64'd0);
        net_ro = 1'b1;
        nicEn = 1'b1; nicWrEn = 1'b1; addr_nic = 2'b10; d_in = 64'h0000_0000_0000_0BAD;
        #1;
        check("col_so_hi", 64'(net_so), 64'd1);
        tick();
        nicEn = 1'b0; nicWrEn = 1'b0;
        check("col_so_lo", 64'(net_so), 64'd0);
        check("col_do", net_do, 64'h8000_0000_0000_0002);
        cpu_rd(2'b11);
        check("col_stat", d_out, 64'd0);

        // Reset mid-transfer with both buffers full
        net_ro = 1'b0;
        net_si = 1'b1; net_di = 64'h0000_0000_00C0_FFEE;
        cpu_wr(2'b10, 64'h8000_0000_0000_0003);
        net_si = 1'b0;
        cpu_rd(2'b10);
        check("pre_rst_dout", d_out, 64'h8000_0000_0000_0003);
        check("pre_rst_ri", 64'(net_ri), 64'd0);
        net_ro = 1'b1;
        #1;
        check("pre_rst_so", 64'(net_so), 64'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_so", 64'(net_so), 64'd0);
        check("mid_rst_ri", 64'(net_ri), 64'd1);
        check("mid_rst_dout", d_out, 64'd0);
        check("mid_rst_do", net_do, 64'd0);
        tick();
        rst = 1'b0;
        cpu_rd(2'b00);
        check("post_rst_inbuf", d_out, 64'd0);
        cpu_rd(2'b01);
        check("post_rst_instat", d_out, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
